// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Summary  : Shares one block-wide memory port between the I-cache refill
//            channel and the D-cache refill/writeback channel, one
//            transaction outstanding, round-robin or data-priority grants.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int BLK_W       = 128,
  parameter int DCACHE_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              ireq_valid_i,
  input  logic [ADDR_W-1:0] ireq_addr_i,
  output logic              ireq_ready_o,
  output logic              ires_valid_o,
  output logic [BLK_W-1:0]  ires_data_o,
  input  logic              dreq_valid_i,
  input  logic [ADDR_W-1:0] dreq_addr_i,
  input  logic              dreq_rw_i,
  input  logic [BLK_W-1:0]  dreq_wdata_i,
  output logic              dreq_ready_o,
  output logic              dres_valid_o,
  output logic [BLK_W-1:0]  dres_data_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_req_addr_o,
  output logic              mem_req_rw_o,
  output logic [BLK_W-1:0]  mem_req_wdata_o,
  input  logic              mem_res_valid_i,
  input  logic [BLK_W-1:0]  mem_res_data_i
);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ISSUE = 2'd1;
  localparam logic [1:0] c_ST_WAIT  = 2'd2;

  localparam logic [1:0] c_OWN_NONE = 2'd0;
  localparam logic [1:0] c_OWN_I    = 2'd1;
  localparam logic [1:0] c_OWN_D    = 2'd2;

  localparam logic c_DPRIO = (DCACHE_PRIO != 0);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic [1:0]        r_owner;
  logic              r_last_d;
  logic              r_drop;
  logic [ADDR_W-1:0] r_addr;
  logic              r_rw;
  logic [BLK_W-1:0]  r_wdata;

  logic w_idle;
  logic w_i_elig;
  logic w_d_elig;
  logic w_grant_i;
  logic w_grant_d;
  logic w_res_fire;
  logic w_busy_i;

  // Readies are also held low while reset is asserted, even though the
  // state register already reads IDLE then.
  assign w_idle     = (r_state == c_ST_IDLE) && !rst_i;
  assign w_i_elig   = w_idle && ireq_valid_i && !flush_i;
  assign w_d_elig   = w_idle && dreq_valid_i;
  // Data wins when alone, when prioritised, or when the instruction side won last.
  assign w_grant_d  = w_d_elig && (!w_i_elig || c_DPRIO || !r_last_d);
  assign w_grant_i  = w_i_elig && !w_grant_d;
  assign w_res_fire = (r_state == c_ST_WAIT) && mem_res_valid_i;
  assign w_busy_i   = (r_owner == c_OWN_I) &&
                      ((r_state == c_ST_ISSUE) || (r_state == c_ST_WAIT));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_ST_IDLE:  if (w_grant_i || w_grant_d) w_next_state = c_ST_ISSUE;
      c_ST_ISSUE: if (mem_req_ready_i)        w_next_state = c_ST_WAIT;
      c_ST_WAIT:  if (mem_res_valid_i)        w_next_state = c_ST_IDLE;
      default:                                w_next_state = c_ST_IDLE;
    endcase
  end

  always_comb begin
    ireq_ready_o    = w_grant_i;
    dreq_ready_o    = w_grant_d;
    mem_req_valid_o = (r_state == c_ST_ISSUE);
    // A flush landing on the response cycle kills it even before r_drop is set.
    ires_valid_o    = w_res_fire && (r_owner == c_OWN_I) && !r_drop && !flush_i;
    dres_valid_o    = w_res_fire && (r_owner == c_OWN_D);
    ires_data_o     = mem_res_data_i;
    dres_data_o     = mem_res_data_i;
    mem_req_addr_o  = r_addr;
    mem_req_rw_o    = r_rw;
    mem_req_wdata_o = r_wdata;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner  <= c_OWN_NONE;
      r_last_d <= 1'b1;
      r_drop   <= 1'b0;
      r_addr   <= '0;
      r_rw     <= 1'b0;
      r_wdata  <= '0;
    end else begin
      if (w_grant_d) begin
        r_addr   <= dreq_addr_i;
        r_rw     <= dreq_rw_i;
        r_wdata  <= dreq_wdata_i;
        r_owner  <= c_OWN_D;
        r_last_d <= 1'b1;
      end else if (w_grant_i) begin
        r_addr   <= ireq_addr_i;
        r_rw     <= 1'b0;
        r_wdata  <= '0;
        r_owner  <= c_OWN_I;
        r_last_d <= 1'b0;
      end
      if (w_busy_i && flush_i) begin
        r_drop <= 1'b1;
      end
      if (w_res_fire) begin
        r_drop  <= 1'b0;
        r_owner <= c_OWN_NONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Summary  : Self-checking bench: memory model, response scoreboard and
//            a second instance built with data priority.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int BW = 128;

  logic clk;
  logic rst_i;
  logic flush_i;
  logic ireq_valid_i, ireq_ready_o, ires_valid_o;
  logic [AW-1:0] ireq_addr_i;
  logic [BW-1:0] ires_data_o;
  logic dreq_valid_i, dreq_rw_i, dreq_ready_o, dres_valid_o;
  logic [AW-1:0] dreq_addr_i;
  logic [BW-1:0] dreq_wdata_i, dres_data_o;
  logic mem_req_valid_o, mem_req_ready_i, mem_req_rw_o, mem_res_valid_i;
  logic [AW-1:0] mem_req_addr_o;
  logic [BW-1:0] mem_req_wdata_o, mem_res_data_i;

  logic p_ireq_ready_o, p_ires_valid_o, p_dreq_ready_o, p_dres_valid_o;
  logic [BW-1:0] p_ires_data_o, p_dres_data_o, p_mem_req_wdata_o, p_mem_res_data_i;
  logic p_mem_req_valid_o, p_mem_req_rw_o, p_mem_res_valid_i;
  logic [AW-1:0] p_mem_req_addr_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_port_arbiter #(.ADDR_W(AW), .BLK_W(BW), .DCACHE_PRIO(0)) u_dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .ireq_valid_i(ireq_valid_i), .ireq_addr_i(ireq_addr_i), .ireq_ready_o(ireq_ready_o),
    .ires_valid_o(ires_valid_o), .ires_data_o(ires_data_o),
    .dreq_valid_i(dreq_valid_i), .dreq_addr_i(dreq_addr_i), .dreq_rw_i(dreq_rw_i),
    .dreq_wdata_i(dreq_wdata_i), .dreq_ready_o(dreq_ready_o),
    .dres_valid_o(dres_valid_o), .dres_data_o(dres_data_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_rw_o(mem_req_rw_o),
    .mem_req_wdata_o(mem_req_wdata_o), .mem_res_valid_i(mem_res_valid_i),
    .mem_res_data_i(mem_res_data_i)
  );

  // Data-priority instance: both channels request forever, memory always ready.
  mem_port_arbiter #(.ADDR_W(AW), .BLK_W(BW), .DCACHE_PRIO(1)) u_dut_prio (
    .clk_i(clk), .rst_i(rst_i), .flush_i(1'b0),
    .ireq_valid_i(1'b1), .ireq_addr_i(32'h0000_1000), .ireq_ready_o(p_ireq_ready_o),
    .ires_valid_o(p_ires_valid_o), .ires_data_o(p_ires_data_o),
    .dreq_valid_i(1'b1), .dreq_addr_i(32'h0000_2000), .dreq_rw_i(1'b0),
    .dreq_wdata_i('0), .dreq_ready_o(p_dreq_ready_o),
    .dres_valid_o(p_dres_valid_o), .dres_data_o(p_dres_data_o),
    .mem_req_valid_o(p_mem_req_valid_o), .mem_req_ready_i(1'b1),
    .mem_req_addr_o(p_mem_req_addr_o), .mem_req_rw_o(p_mem_req_rw_o),
    .mem_req_wdata_o(p_mem_req_wdata_o), .mem_res_valid_i(p_mem_res_valid_i),
    .mem_res_data_i(p_mem_res_data_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [AW-1:0] addr; logic rw; logic [BW-1:0] wdata; } mreq_t;
  typedef struct { logic rw; logic [BW-1:0] data; } dexp_t;
  typedef struct {
    logic is_d; logic rw; logic [AW-1:0] addr; logic [BW-1:0] wdata;
    int rdy; int rsp; logic [BW-1:0] exp_data;
  } vec_t;

  mreq_t mq[$];
  logic [BW-1:0] iq[$];
  dexp_t dq[$];

  int rdy_dly = 0, rsp_dly = 1, mm_phase = 0, mm_cnt = 0;
  int last_res_cyc = -1, igrant_cyc = -1, dgrant_cyc = -1;
  logic [AW-1:0] mm_addr;
  logic p_prev = 1'b0;
  int p_igr = 0, p_dgr = 0, p_dres = 0;

  function automatic logic [BW-1:0] mem_data(input logic [AW-1:0] a);
    if (a == 32'h8000_0040) return {16{8'hA5}};
    return {~a, a, a ^ 32'h0F0F_0F0F, a + 32'h11};
  endfunction

  task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Memory model: accepts after rdy_dly ISSUE cycles, answers rsp_dly cycles later.
  initial begin
    mreq_t e;
    mem_req_ready_i = 1'b0; mem_res_valid_i = 1'b0; mem_res_data_i = '0;
    forever begin
      @(posedge clk); #1;
      mem_req_ready_i = 1'b0; mem_res_valid_i = 1'b0; mem_res_data_i = '0;
      if (rst_i) begin
        mm_phase = 0; mm_cnt = 0;
      end else if (mm_phase == 0) begin
        if (mem_req_valid_o) begin
          if (mm_cnt >= rdy_dly) begin
            mem_req_ready_i = 1'b1; mm_addr = mem_req_addr_o; mm_phase = 1; mm_cnt = 0;
            checks++;
            if (mq.size() == 0) begin
              errors++;
              $display("FAIL mem_req_unexpected addr=%h", mem_req_addr_o);
            end else begin
              e = mq.pop_front();
              if (mem_req_addr_o !== e.addr || mem_req_rw_o !== e.rw ||
                  (e.rw && mem_req_wdata_o !== e.wdata)) begin
                errors++;
                $display("FAIL mem_req got addr=%h rw=%b wd=%h exp addr=%h rw=%b wd=%h",
                         mem_req_addr_o, mem_req_rw_o, mem_req_wdata_o, e.addr, e.rw, e.wdata);
              end
            end
          end else begin
            mm_cnt++;
          end
        end
      end else begin
        mm_cnt++;
        if (mm_cnt >= rsp_dly) begin
          mem_res_valid_i = 1'b1; mem_res_data_i = mem_data(mm_addr);
          last_res_cyc = cyc; mm_phase = 0; mm_cnt = 0;
        end
      end
    end
  end

  initial begin
    p_mem_res_valid_i = 1'b0; p_mem_res_data_i = '0;
    forever begin
      @(posedge clk); #1;
      p_mem_res_valid_i = p_prev && !rst_i;
      p_mem_res_data_i  = {4{32'hCAFE_0000}};
    end
  end

  // Response scoreboard and per-cycle invariants.
  initial begin
    logic [BW-1:0] x;
    dexp_t d;
    forever begin
      @(negedge clk);
      checks++;
      if (ireq_ready_o && dreq_ready_o) begin
        errors++; $display("FAIL both_ready got=11 exp=not both");
      end
      if (ires_valid_o) begin
        checks++;
        if (iq.size() == 0) begin
          errors++; $display("FAIL ires_unexpected data=%h exp=no response", ires_data_o);
        end else begin
          x = iq.pop_front();
          if (ires_data_o !== x) begin
            errors++; $display("FAIL ires_data got=%h exp=%h", ires_data_o, x);
          end
        end
      end
      if (dres_valid_o) begin
        checks++;
        if (dq.size() == 0) begin
          errors++; $display("FAIL dres_unexpected data=%h exp=no response", dres_data_o);
        end else begin
          d = dq.pop_front();
          if (!d.rw && dres_data_o !== d.data) begin
            errors++; $display("FAIL dres_data got=%h exp=%h", dres_data_o, d.data);
          end
        end
      end
      p_prev = p_mem_req_valid_o;
      if (p_ireq_ready_o) p_igr++;
      if (p_dreq_ready_o) p_dgr++;
      if (p_dres_valid_o) begin
        p_dres++;
        chk("prio_dres_data", p_dres_data_o, {4{32'hCAFE_0000}});
      end
    end
  end

  // Requester tasks start and end at the drive point (#1 after posedge).
  task automatic ireq(input logic [AW-1:0] a, input logic [BW-1:0] exp, input bit resp);
    bit ok = 1'b0;
    if (resp) iq.push_back(exp);
    ireq_valid_i = 1'b1; ireq_addr_i = a;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ireq_ready_o) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ireq_grant_timeout addr=%h got=no grant exp=grant", a); end
    igrant_cyc = cyc;
    @(posedge clk); #1;
    ireq_valid_i = 1'b0;
  endtask

  task automatic dreq(input logic rw, input logic [AW-1:0] a, input logic [BW-1:0] wd,
                      input logic [BW-1:0] exp);
    bit ok = 1'b0;
    dq.push_back('{rw: rw, data: exp});
    dreq_valid_i = 1'b1; dreq_addr_i = a; dreq_rw_i = rw; dreq_wdata_i = wd;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (dreq_ready_o) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL dreq_grant_timeout addr=%h got=no grant exp=grant", a); end
    dgrant_cyc = cyc;
    @(posedge clk); #1;
    dreq_valid_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (iq.size() == 0 && dq.size() == 0 && mq.size() == 0 && mm_phase == 0) begin
        ok = 1'b1; break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drain_%s pending i=%0d d=%0d m=%0d exp=0", name, iq.size(), dq.size(), mq.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; flush_i = 1'b0; ireq_valid_i = 1'b0; dreq_valid_i = 1'b0;
    iq.delete(); dq.delete(); mq.delete();
    repeat (2) @(posedge clk);
    #1 rst_i = 1'b0;
  endtask

  localparam logic [AW-1:0] A_I0 = 32'h8000_0100, A_I1 = 32'h8000_0140;
  localparam logic [AW-1:0] A_D0 = 32'h8000_0200, A_D1 = 32'h8000_0240;

  initial begin
    vec_t tbl[6];
    int t0;
    tbl[0] = '{1'b0, 1'b0, 32'h8000_0040, '0, 2, 5, {16{8'hA5}}};
    tbl[1] = '{1'b1, 1'b1, 32'h8000_1000, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321, 0, 1, '0};
    tbl[2] = '{1'b1, 1'b0, 32'h8000_2000, '0, 1, 2, mem_data(32'h8000_2000)};
    tbl[3] = '{1'b0, 1'b0, 32'h8000_3000, '0, 0, 1, mem_data(32'h8000_3000)};
    tbl[4] = '{1'b1, 1'b0, 32'h0000_0FF0, '0, 3, 3, mem_data(32'h0000_0FF0)};
    tbl[5] = '{1'b1, 1'b1, 32'hFFFF_FFF0, {BW{1'b1}}, 0, 1, '0};

    rst_i = 1'b1; flush_i = 1'b0;
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h8000_0040;
    dreq_valid_i = 1'b1; dreq_addr_i = '0; dreq_rw_i = 1'b0; dreq_wdata_i = '0;
    @(negedge clk);
    chk("rst_ireq_ready", BW'(ireq_ready_o), '0);
    chk("rst_dreq_ready", BW'(dreq_ready_o), '0);
    chk("rst_mem_valid", BW'(mem_req_valid_o), '0);
    chk("rst_res_valid", BW'({ires_valid_o, dres_valid_o}), '0);
    chk("rst_addr", BW'(mem_req_addr_o), '0);
    chk("rst_rw", BW'(mem_req_rw_o), '0);
    chk("rst_wdata", mem_req_wdata_o, '0);
    @(posedge clk); #1;
    ireq_valid_i = 1'b0; dreq_valid_i = 1'b0; rst_i = 1'b0;

    for (int k = 0; k < 6; k++) begin
      rdy_dly = tbl[k].rdy; rsp_dly = tbl[k].rsp;
      mq.push_back('{addr: tbl[k].addr, rw: tbl[k].is_d & tbl[k].rw, wdata: tbl[k].wdata});
      t0 = cyc;
      if (tbl[k].is_d) begin
        dreq(tbl[k].rw, tbl[k].addr, tbl[k].wdata, tbl[k].exp_data);
        chk("grant_latency_d", BW'(dgrant_cyc), BW'(t0));
      end else begin
        ireq(tbl[k].addr, tbl[k].exp_data, 1'b1);
        chk("grant_latency_i", BW'(igrant_cyc), BW'(t0));
      end
      wait_drain("table");
    end

    // Round-robin ties: I, D, I, D.
    do_reset(); rdy_dly = 0; rsp_dly = 1;
    mq.push_back('{A_I0, 1'b0, '0}); mq.push_back('{A_D0, 1'b0, '0});
    mq.push_back('{A_I1, 1'b0, '0}); mq.push_back('{A_D1, 1'b0, '0});
    fork
      begin ireq(A_I0, mem_data(A_I0), 1'b1); ireq(A_I1, mem_data(A_I1), 1'b1); end
      begin dreq(1'b0, A_D0, '0, mem_data(A_D0)); dreq(1'b0, A_D1, '0, mem_data(A_D1)); end
    join
    wait_drain("rr");

    // Flush while the refill waits; pending data request goes the cycle after.
    do_reset(); rdy_dly = 0; rsp_dly = 4;
    mq.push_back('{32'h8000_0500, 1'b0, '0}); mq.push_back('{32'h8000_0600, 1'b0, '0});
    ireq(32'h8000_0500, '0, 1'b0);
    fork
      begin @(posedge clk); #1 flush_i = 1'b1; @(posedge clk); #1 flush_i = 1'b0; end
      dreq(1'b0, 32'h8000_0600, '0, mem_data(32'h8000_0600));
    join
    chk("flush_next_grant_cyc", BW'(dgrant_cyc), BW'(last_res_cyc + 1));
    wait_drain("flush_wait");

    // Flush on the response cycle, then a normal refill proves drop was cleared.
    rdy_dly = 0; rsp_dly = 2;
    mq.push_back('{32'h8000_0700, 1'b0, '0});
    ireq(32'h8000_0700, '0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1 flush_i = 1'b0;
    wait_drain("flush_same");
    mq.push_back('{32'h8000_0740, 1'b0, '0});
    ireq(32'h8000_0740, mem_data(32'h8000_0740), 1'b1);
    wait_drain("after_drop");

    // Flush during a data-owned transaction must not suppress it.
    mq.push_back('{32'h8000_0800, 1'b0, '0});
    dreq(1'b0, 32'h8000_0800, '0, mem_data(32'h8000_0800));
    @(posedge clk); #1 flush_i = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 flush_i = 1'b0;
    wait_drain("flush_data");

    // Flush in IDLE with both valid: data is granted, instruction after.
    do_reset(); rdy_dly = 0; rsp_dly = 1;
    mq.push_back('{32'h8000_0900, 1'b0, '0}); mq.push_back('{32'h8000_0A00, 1'b0, '0});
    dq.push_back('{rw: 1'b0, data: mem_data(32'h8000_0900)});
    ireq_valid_i = 1'b1; ireq_addr_i = 32'h8000_0A00;
    dreq_valid_i = 1'b1; dreq_addr_i = 32'h8000_0900; dreq_rw_i = 1'b0; flush_i = 1'b1;
    @(negedge clk);
    chk("idle_flush_ireq_ready", BW'(ireq_ready_o), '0);
    chk("idle_flush_dreq_ready", BW'(dreq_ready_o), BW'(1'b1));
    @(posedge clk); #1 dreq_valid_i = 1'b0; flush_i = 1'b0;
    ireq(32'h8000_0A00, mem_data(32'h8000_0A00), 1'b1);
    chk("idle_flush_i_after_d", BW'(igrant_cyc), BW'(last_res_cyc + 1));
    wait_drain("idle_flush");

    // Asynchronous reset in ISSUE, then the first tie goes to the instruction side.
    rdy_dly = 5; rsp_dly = 1;
    mq.push_back('{32'h8000_0B00, 1'b0, '0});
    ireq(32'h8000_0B00, '0, 1'b0);
    chk("issue_valid", BW'(mem_req_valid_o), BW'(1'b1));
    #2 rst_i = 1'b1;
    #1;
    chk("async_rst_valid", BW'(mem_req_valid_o), '0);
    chk("async_rst_addr", BW'(mem_req_addr_o), '0);
    iq.delete(); dq.delete(); mq.delete();
    @(posedge clk); #1;
    @(posedge clk); #1 rst_i = 1'b0;
    rdy_dly = 0;
    mq.push_back('{32'h8000_0C00, 1'b0, '0}); mq.push_back('{32'h8000_0D00, 1'b1, {4{32'h0BAD_F00D}}});
    fork
      ireq(32'h8000_0C00, mem_data(32'h8000_0C00), 1'b1);
      dreq(1'b1, 32'h8000_0D00, {4{32'h0BAD_F00D}}, '0);
    join
    wait_drain("post_rst");

    chk("prio_i_grants", BW'(p_igr), '0);
    chk("prio_d_grants_min", BW'(p_dgr >= 4), BW'(1'b1));
    chk("prio_d_resp_min", BW'(p_dres >= 3), BW'(1'b1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
